maxpool2_col_stream: RTL and testbench
======================================

Name: maxpool2_col_stream

Overview:
- Downstream stage of the 5x5 convolution row engine.
- Consumes one column of parallel convolution results per beat (IN_ROWS lanes, signed DATA_WIDTH).
- Performs 2x2 stride-2 max pooling with optional ReLU, emitting one pooled column of IN_ROWS/2 lanes per input column pair.
- Frame-based: armed by start, signals done after IN_COLS/2 pooled columns have been delivered.

Parameters:
- DATA_WIDTH, 32, width of each signed lane (matches the convolution output width).
- IN_ROWS, 24, lanes per input column (IMAGE_SIZE-KERNEL_SIZE+1); must be even.
- IN_COLS, 24, input columns per frame; must be even.
- RELU_EN, 1, when 1 clamp pooled results to max(result, 0).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-low reset
- start  input  1  arms a frame; sampled only in IDLE
- in_valid  input  1  in_data carries a column
- in_ready  output  1  block accepts column this cycle
- in_data  input  IN_ROWS x DATA_WIDTH  signed column lanes, lane 0 = top row
- out_valid  output  1  out_data holds a pooled column
- out_ready  input  1  consumer accepts out_data
- out_data  output  IN_ROWS/2 x DATA_WIDTH  signed pooled lanes
- out_col  output  $clog2(IN_COLS/2)+1  index of pooled column on out_data
- done  output  1  one-cycle pulse at frame end

Behaviour:
- Handshakes: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
- Reset (rst=0 at clk edge):
  - state=IDLE; in_ready=0, out_valid=0, done=0, out_col=0, out_data all 0.
  - Column buffer and pair counter cleared.
- States:
  - IDLE: in_ready=0. start=1 -> FIRST.
  - FIRST: in_ready=1. On transfer, latch in_data into col_buf -> SECOND.
  - SECOND: in_ready = !out_valid | out_ready. On transfer:
    - out_data[k] = max(col_buf[2k], col_buf[2k+1], in_data[2k], in_data[2k+1]), signed compare, then ReLU if RELU_EN.
    - out_valid<=1; out_col<=pair_cnt; pair_cnt++.
    - If pair_cnt was IN_COLS/2-1 -> DRAIN, else -> FIRST.
  - DRAIN: in_ready=0; wait for output transfer of the final column -> COMPLETE.
  - COMPLETE: done=1 for exactly one cycle -> IDLE.
- Output register:
  - out_valid clears on output transfer unless reloaded in the same cycle.
  - A simultaneous drain and reload in SECOND is legal: the new data wins and out_valid stays 1.
  - out_data and out_col are stable while out_valid & !out_ready.
- Timing:
  - Latency: pooled column valid on the cycle after the second column of a pair transfers.
  - Throughput: one input column per cycle when out_ready is held high; no bubbles.
  - FIRST accepts even while out_valid is pending (col_buf is independent of the output register).
- Arithmetic:
  - Lanes are two's complement; no width growth.
  - Equal values: any operand is acceptable since the result value is identical.
  - ReLU maps negatives, including the most-negative value, to 0.
- Boundaries:
  - start outside IDLE is ignored.
  - in_valid while in_ready=0 is not consumed and the data is not sampled.
  - rst low mid-frame aborts: buffered column and pending output are discarded, state returns to IDLE, and no done pulse is issued.
  - done is never asserted together with out_valid.

Test Plan:
1. Reset, then start, then 24 columns with in_data[r] = r + 100*c, out_ready=1 -> 12 outputs; out_col 0..11; out_data[k] for pair p = (2k+1) + 100*(2p+1); done pulses once, one cycle after the last output transfer.
2. RELU_EN=1, all inputs -5 except lane 3 of column 1 = -1 -> pair 0 out_data all 0. Same run with RELU_EN=0 -> out_data[1] = -1, other lanes -5.
3. Backpressure: out_ready=0 for 5 cycles after the first output with in_valid held -> in_ready=1 for column 2, in_ready=0 in SECOND; out_data/out_col held at pair 0; no data lost once out_ready rises.
4. Same-cycle drain and reload: out_ready=1 while the 4th column arrives -> out_valid stays 1, out_col steps 0->1 with no gap.
5. Signed extremes: lanes 0x80000000 and 0x7FFFFFFF in one window -> 0x7FFFFFFF. A window of all 0x80000000 with RELU_EN=1 -> 0.
6. rst=0 after 7 columns with an output pending -> next cycle out_valid=0, in_ready=0, state IDLE. A new start plus 24 columns -> out_col restarts at 0 and exactly one done pulse.

Source files
------------

// File: rtl/maxpool2_col_stream.sv
// rtl/maxpool2_col_stream.sv - 2x2 stride-2 column-streaming max pool with optional ReLU
module maxpool2_col_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int IN_ROWS    = 24,
    parameter int IN_COLS    = 24,
    parameter int RELU_EN    = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [IN_ROWS-1:0][DATA_WIDTH-1:0]     in_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [IN_ROWS/2-1:0][DATA_WIDTH-1:0]   out_data,
    output logic [$clog2(IN_COLS/2):0]             out_col,
    output logic                                   done
);

    localparam int OUT_ROWS = IN_ROWS / 2;
    localparam int CNT_W    = $clog2(IN_COLS/2) + 1;
    localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(IN_COLS/2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FIRST,
        S_SECOND,
        S_DRAIN,
        S_COMPLETE
    } state_t;

    state_t                                  r_state;
    state_t                                  w_next;
    logic                                    w_in_ready;
    logic                                    w_done;
    logic                                    w_buf_load;
    logic                                    w_out_load;
    logic                                    w_out_xfer;

    logic [IN_ROWS-1:0][DATA_WIDTH-1:0]      r_col_buf;
    logic [OUT_ROWS-1:0][DATA_WIDTH-1:0]     r_out_data;
    logic [OUT_ROWS-1:0][DATA_WIDTH-1:0]     w_pool;
    logic                                    r_out_valid;
    logic [CNT_W-1:0]                        r_out_col;
    logic [CNT_W-1:0]                        r_pair_cnt;

    function automatic logic signed [DATA_WIDTH-1:0] smax(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] relu(
        input logic signed [DATA_WIDTH-1:0] a
    );
        if ((RELU_EN != 0) && a[DATA_WIDTH-1])
            return '0;
        return a;
    endfunction

    assign w_out_xfer = r_out_valid & out_ready;
    assign w_buf_load = (r_state == S_FIRST) & in_valid;
    assign w_out_load = (r_state == S_SECOND) & in_valid & w_in_ready;

    assign in_ready  = w_in_ready;
    assign done      = w_done;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_col   = r_out_col;

    // Frame sequencing: next state, input acceptance and the done pulse
    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start)
                    w_next = S_FIRST;
            end
            S_FIRST: begin
                // col_buf is separate from the output register, so a pending output never stalls here
                w_in_ready = 1'b1;
                if (in_valid)
                    w_next = S_SECOND;
            end
            S_SECOND: begin
                // Room exists if the output register is empty or being drained this cycle
                w_in_ready = !r_out_valid | out_ready;
                if (in_valid && w_in_ready)
                    w_next = (r_pair_cnt == LAST_PAIR) ? S_DRAIN : S_FIRST;
            end
            S_DRAIN: begin
                if (w_out_xfer)
                    w_next = S_COMPLETE;
            end
            S_COMPLETE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Pooled lane k is the max of the 2x2 window formed by rows 2k/2k+1 of the buffered and incoming columns
    always_comb begin
        w_pool = '0;
        for (int k = 0; k < OUT_ROWS; k++) begin
            w_pool[k] = relu(smax(smax($signed(r_col_buf[2*k]), $signed(r_col_buf[2*k+1])),
                                  smax($signed(in_data[2*k]),   $signed(in_data[2*k+1]))));
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Column buffer: holds the first column of each pair
    always_ff @(posedge clk) begin
        if (!rst)
            r_col_buf <= '0;
        else if (w_buf_load)
            r_col_buf <= in_data;
    end

    // Output register: a reload in the same cycle as a drain keeps out_valid high with the new column
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_col   <= '0;
        end else if (w_out_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_pool;
            r_out_col   <= r_pair_cnt;
        end else if (w_out_xfer) begin
            r_out_valid <= 1'b0;
        end
    end

    // Pair counter: counts pooled columns within the frame, restarts from zero on each frame
    always_ff @(posedge clk) begin
        if (!rst)
            r_pair_cnt <= '0;
        else if (r_state == S_IDLE)
            r_pair_cnt <= '0;
        else if (w_out_load)
            r_pair_cnt <= (r_pair_cnt == LAST_PAIR) ? '0 : r_pair_cnt + 1'b1;
    end

endmodule

// File: tb/tb_maxpool2_col_stream.sv
// tb/tb_maxpool2_col_stream.sv - self-checking bench for maxpool2_col_stream
module tb_maxpool2_col_stream;

    localparam int DW  = 32;
    localparam int NR  = 24;
    localparam int NC  = 24;
    localparam int NH  = NR / 2;
    localparam int NP  = NC / 2;
    localparam int OCW = $clog2(NC/2) + 1;

    typedef logic [NR-1:0][DW-1:0] col_t;
    typedef logic [NH-1:0][DW-1:0] pcol_t;
    typedef struct {
        pcol_t relu;
        pcol_t raw;
        int    col;
    } exp_t;
    typedef struct {
        int bg;
        int lane;
        int w0, w1, w2, w3;
        int exp_raw;
        int exp_relu;
        int bg_raw;
        int bg_relu;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b0;
    col_t           in_data = '0;
    logic           in_ready_a, out_valid_a, done_a;
    logic           in_ready_b, out_valid_b, done_b;
    pcol_t          out_data_a, out_data_b;
    logic [OCW-1:0] out_col_a, out_col_b;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   idx = 0;
    int   done_cnt = 0;
    int   last_out_cyc = -10;
    int   first_in_cyc = 0;
    int   last_in_cyc = 0;
    bit   mon_en = 1'b0;
    col_t frm [NC];
    exp_t exp_q [$];
    exp_t mon_e;
    vec_t vt [NP];

    maxpool2_col_stream #(.DATA_WIDTH(DW), .IN_ROWS(NR), .IN_COLS(NC), .RELU_EN(1)) u_relu (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_data(out_data_a), .out_col(out_col_a), .done(done_a)
    );

    maxpool2_col_stream #(.DATA_WIDTH(DW), .IN_ROWS(NR), .IN_COLS(NC), .RELU_EN(0)) u_raw (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .out_col(out_col_b), .done(done_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [NH*DW-1:0] got, input logic [NH*DW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    function automatic col_t rand_col();
        col_t c;
        for (int r = 0; r < NR; r++) begin
            case ($urandom_range(0, 5))
                0:       c[r] = 32'h8000_0000;
                1:       c[r] = 32'h7fff_ffff;
                2:       c[r] = 32'($urandom_range(0, 20)) - 32'd10;
                default: c[r] = $urandom;
            endcase
        end
        return c;
    endfunction

    // Reference: each pooled lane is the largest of four signed integers, ReLU applied separately
    task automatic push_model();
        exp_t e;
        int   v [4];
        int   m;
        for (int p = 0; p < NP; p++) begin
            for (int k = 0; k < NH; k++) begin
                v[0] = frm[2*p][2*k];
                v[1] = frm[2*p][2*k+1];
                v[2] = frm[2*p+1][2*k];
                v[3] = frm[2*p+1][2*k+1];
                m = v[0];
                for (int j = 1; j < 4; j++)
                    if (v[j] > m) m = v[j];
                e.raw[k]  = m;
                e.relu[k] = (m < 0) ? 0 : m;
            end
            e.col = p;
            exp_q.push_back(e);
        end
    endtask

    task automatic rand_frame();
        for (int c = 0; c < NC; c++) frm[c] = rand_col();
    endtask

    task automatic begin_frame();
        @(posedge clk); #1;
        start = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        idx = 0;
    endtask

    task automatic step(input bit v, input bit rdy);
        @(posedge clk); #1;
        in_valid  = v;
        in_data   = (idx < NC) ? frm[idx] : rand_col();
        out_ready = rdy;
        @(negedge clk);
        if (v && in_ready_a && idx < NC) begin
            if (idx == 0) first_in_cyc = cyc;
            idx++;
            last_in_cyc = cyc;
        end
    endtask

    task automatic drive_rest(input bit rnd);
        int budget;
        int d0;
        budget = 3000;
        d0 = done_cnt;
        while (done_cnt == d0 && budget > 0) begin
            @(posedge clk); #1;
            budget--;
            if (idx < NC) begin
                in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                in_data  = in_valid ? frm[idx] : rand_col();
                start    = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            end else begin
                in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                in_data  = rand_col();
                start    = 1'b0;
            end
            out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(negedge clk);
            if (in_valid && in_ready_a) begin
                if (idx < NC) begin
                    idx++;
                    last_in_cyc = cyc;
                end else begin
                    check("extra_accept", in_ready_a, 0);
                end
            end
        end
        start = 1'b0;
        in_valid = 1'b0;
        check("frame_done_once", done_cnt - d0, 1);
    endtask

    // Output scoreboard and done-pulse checks
    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid_a && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output got=col%0d want=none", out_col_a);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_data_relu", out_data_a, mon_e.relu);
                    check("out_data_raw", out_data_b, mon_e.raw);
                    check("out_col_relu", out_col_a, mon_e.col);
                    check("out_col_raw", out_col_b, mon_e.col);
                    check("out_valid_raw", out_valid_b, 1);
                end
                last_out_cyc = cyc;
            end
            if (done_a) begin
                done_cnt++;
                check("done_no_valid", out_valid_a, 0);
                check("done_raw", done_b, 1);
                check("done_after_last", cyc, last_out_cyc + 1);
                check("done_all_outputs", exp_q.size(), 0);
            end
        end
    end

    initial begin
        exp_t e;
        int   d0;

        vt[0]  = '{-5,        1, -5, -5, -5, -1,                                       -1, 0, -5, 0};
        vt[1]  = '{0,         0, 32'h8000_0000, 32'h7fff_ffff, 32'h8000_0000, 32'h8000_0000,
                   32'h7fff_ffff, 32'h7fff_ffff, 0, 0};
        vt[2]  = '{32'h8000_0000, 5, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                   32'h8000_0000, 0, 32'h8000_0000, 0};
        vt[3]  = '{7,        11, 1, 2, 3, 100,                                         100, 100, 7, 7};
        vt[4]  = '{-1,        0, -3, -2, -7, -9,                                       -2, 0, -1, 0};
        vt[5]  = '{3,         6, 50, -50, -60, 49,                                     50, 50, 3, 3};
        vt[6]  = '{1,         2, 5, 5, 5, 5,                                           5, 5, 1, 1};
        vt[7]  = '{32'h7fff_ffff, 4, 32'h7fff_fffe, 32'h7fff_fffe, 32'h7fff_fffe, 32'h7fff_fffe,
                   32'h7fff_fffe, 32'h7fff_fffe, 32'h7fff_ffff, 32'h7fff_ffff};
        vt[8]  = '{-100,      9, -1, -100, -200, -300,                                 -1, 0, -100, 0};
        vt[9]  = '{0,        10, 0, -1, 0, -1,                                         0, 0, 0, 0};
        vt[10] = '{2,         7, -4, 9, 8, -7,                                         9, 9, 2, 2};
        vt[11] = '{-2,        3, -8, -3, -6, -4,                                       -3, 0, -2, 0};

        // Reset state
        rand_frame();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready_a, 0);
        check("rst_out_valid", out_valid_a, 0);
        check("rst_out_valid_raw", out_valid_b, 0);
        check("rst_done", done_a, 0);
        check("rst_out_col", out_col_a, 0);
        check("rst_out_data", out_data_a, 0);
        check("rst_out_data_raw", out_data_b, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        mon_en = 1'b1;

        // Idle ignores in_valid
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1);
            check("idle_in_ready", in_ready_a, 0);
        end

        // Ramp frame, full rate, with same-cycle drain and reload on the 4th column
        for (int c = 0; c < NC; c++)
            for (int r = 0; r < NR; r++)
                frm[c][r] = r + 100 * c;
        push_model();
        begin_frame();
        step(1'b1, 1'b1);
        check("t1_c0_ready", in_ready_a, 1);
        check("t1_c0_nvalid", out_valid_a, 0);
        step(1'b1, 1'b1);
        check("t1_c1_ready", in_ready_a, 1);
        step(1'b1, 1'b0);
        check("t1_first_valid", out_valid_a, 1);
        check("t1_first_col", out_col_a, 0);
        check("t1_lane0", out_data_a[0], 101);
        check("t1_lane11", out_data_a[11], 123);
        check("t1_c2_ready_pending", in_ready_a, 1);
        step(1'b1, 1'b1);
        check("t4_c3_ready", in_ready_a, 1);
        check("t4_c3_valid", out_valid_a, 1);
        check("t4_c3_col", out_col_a, 0);
        step(1'b1, 1'b1);
        check("t4_no_gap_valid", out_valid_a, 1);
        check("t4_no_gap_col", out_col_a, 1);
        drive_rest(1'b0);
        check("t1_throughput", last_in_cyc - first_in_cyc, NC - 1);

        // Backpressure after first output
        rand_frame();
        push_model();
        begin_frame();
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        check("t3_first_ready", in_ready_a, 1);
        check("t3_first_valid", out_valid_a, 1);
        e = exp_q[0];
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0);
            check("t3_second_blocked", in_ready_a, 0);
            check("t3_hold_col", out_col_a, 0);
            check("t3_hold_data", out_data_a, e.relu);
        end
        drive_rest(1'b1);

        // Table of windows: ReLU, signed extremes, ties
        for (int p = 0; p < NP; p++) begin
            for (int r = 0; r < NR; r++) begin
                frm[2*p][r]   = vt[p].bg;
                frm[2*p+1][r] = vt[p].bg;
            end
            frm[2*p][2*vt[p].lane]     = vt[p].w0;
            frm[2*p][2*vt[p].lane+1]   = vt[p].w1;
            frm[2*p+1][2*vt[p].lane]   = vt[p].w2;
            frm[2*p+1][2*vt[p].lane+1] = vt[p].w3;
            for (int k = 0; k < NH; k++) begin
                e.raw[k]  = (k == vt[p].lane) ? vt[p].exp_raw  : vt[p].bg_raw;
                e.relu[k] = (k == vt[p].lane) ? vt[p].exp_relu : vt[p].bg_relu;
            end
            e.col = p;
            exp_q.push_back(e);
        end
        begin_frame();
        drive_rest(1'b1);

        // Abort mid-frame with an output pending
        rand_frame();
        push_model();
        begin_frame();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        check("t6_c6_ready", in_ready_a, 1);
        check("t6_pending", out_valid_a, 1);
        d0 = done_cnt;
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("t6_abort_valid", out_valid_a, 0);
        check("t6_abort_ready", in_ready_a, 0);
        check("t6_abort_done", done_a, 0);
        check("t6_abort_col", out_col_a, 0);
        exp_q.delete();
        idx = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1);
            check("t6_idle_ready", in_ready_a, 0);
        end
        check("t6_no_done", done_cnt - d0, 0);
        rand_frame();
        push_model();
        begin_frame();
        drive_rest(1'b1);

        // Further random frames
        for (int f = 0; f < 3; f++) begin
            rand_frame();
            push_model();
            begin_frame();
            drive_rest(1'b1);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
